// File: rtl/latch_sync_debounce_pkg.sv
// Shared types and default parameters for the latch output synchronizer/debouncer.
// Optional glitch counter in latch_sync_debounce is enabled by LATCH_SYNC_GLITCH_CNT_EN.
package latch_sync_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        ARM_HI    = 2'd1,
        STABLE_HI = 2'd2,
        ARM_LO    = 2'd3
    } deb_state_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_DEB_CYCLES  = 4;
    localparam int unsigned DEF_CNT_W       = 8;

endpackage

// File: rtl/latch_sync_debounce_sync_chain.sv
// Plain flop chain bringing an asynchronous bit into the i_clk domain.
// Stage 0 samples i_d; o_q is the last stage; nothing sits between stages.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/latch_sync_debounce.sv
// Synchronizes and debounces the D-latch output, producing a clean level, edge pulses and a rise counter.
// Define LATCH_SYNC_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module latch_sync_debounce
    import latch_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             q_in,
    input  logic             clr_cnt,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             cnt_ovf,
`ifdef LATCH_SYNC_GLITCH_CNT_EN
    output logic [CNT_W-1:0] glitch_cnt,
`endif
    output deb_state_t       o_dbg_state
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             w_s;
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [DEB_W-1:0] w_deb_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             w_abort;
    logic [CNT_W-1:0] r_evt_cnt;
    logic             r_ovf;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_d    (q_in),
        .o_q    (w_s)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= STABLE_LO;
            r_deb_cnt <= '0;
            r_level   <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_nxt;
            r_level   <= w_level_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
        end
    end

    // Any sample disagreeing with the armed direction drops back to the stable state it came from.
    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    w_state_nxt = ARM_HI;
                    w_deb_nxt   = DEB_ONE;
                end
            end
            ARM_HI: begin
                if (!w_s) begin
                    w_state_nxt = STABLE_LO;
                    w_deb_nxt   = '0;
                    w_abort     = 1'b1;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = STABLE_HI;
                    w_deb_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_deb_nxt = r_deb_cnt + DEB_ONE;
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    w_state_nxt = ARM_LO;
                    w_deb_nxt   = DEB_ONE;
                end
            end
            ARM_LO: begin
                if (w_s) begin
                    w_state_nxt = STABLE_HI;
                    w_deb_nxt   = '0;
                    w_abort     = 1'b1;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = STABLE_LO;
                    w_deb_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_deb_nxt = r_deb_cnt + DEB_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_deb_nxt   = '0;
            end
        endcase
    end

    // Clear wins over a same-edge rise: that event is dropped from the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_evt_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (clr_cnt) begin
            r_evt_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (w_rise_nxt) begin
            r_evt_cnt <= r_evt_cnt + CNT_W'(1);
            if (&r_evt_cnt) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef LATCH_SYNC_GLITCH_CNT_EN
    logic [CNT_W-1:0] r_glitch_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_glitch_cnt <= '0;
        end else if (clr_cnt) begin
            r_glitch_cnt <= '0;
        end else if (w_abort && !(&r_glitch_cnt)) begin
            r_glitch_cnt <= r_glitch_cnt + CNT_W'(1);
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`else
    logic w_abort_unused;
    assign w_abort_unused = w_abort;
`endif

    assign level_out   = r_level;
    assign rise_pulse  = r_rise;
    assign fall_pulse  = r_fall;
    assign evt_cnt     = r_evt_cnt;
    assign cnt_ovf     = r_ovf;
    assign o_dbg_state = r_state;

endmodule
